// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: resolves load-use, taken-branch
// and data-memory wait hazards into per-stage load/bubble controls plus perf counters.
module pipeline_hazard_controller #(
    parameter int COUNTER_WIDTH = 32,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               idRs1,
    input  logic [4:0]               idRs2,
    input  logic                     idUsesRs1,
    input  logic                     idUsesRs2,
    input  logic [4:0]               exRd,
    input  logic                     exMemoryReadEnable,
    input  logic                     memBranch,
    input  logic                     memBranchEnable,
    input  logic                     memMemoryReadEnable,
    input  logic                     memMemoryWriteEnable,
    input  logic                     dmemReady,
    output logic                     pcWrite,
    output logic                     ifIdWrite,
    output logic                     idExWrite,
    output logic                     exMemWrite,
    output logic                     memWbWrite,
    output logic                     ifIdFlush,
    output logic                     idExFlush,
    output logic                     exMemFlush,
    output logic                     memWbFlush,
    output logic                     pcSelectBranch,
    output logic [COUNTER_WIDTH-1:0] stallCount,
    output logic [COUNTER_WIDTH-1:0] flushCount,
    output logic                     memError,
    output logic [1:0]               state
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam int WAIT_WIDTH = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MEM_TIMEOUT);
    localparam logic [WAIT_WIDTH-1:0] WAIT_LAST  = WAIT_WIDTH'(MEM_TIMEOUT - 1);

    state_t                current_state;
    state_t                next_state;
    logic [WAIT_WIDTH-1:0] wait_count;
    logic                  mem_pending;
    logic                  branch_taken;
    logic                  load_use;
    logic                  do_stall;
    logic                  do_branch;
    logic                  do_load_use;
    logic                  wait_increment;
    logic                  wait_clear;

    assign mem_pending  = (memMemoryReadEnable | memMemoryWriteEnable) & ~dmemReady;
    assign branch_taken = memBranch & memBranchEnable;
    assign load_use     = exMemoryReadEnable && (exRd != 5'd0) &&
                          ((idUsesRs1 && (idRs1 == exRd)) || (idUsesRs2 && (idRs2 == exRd)));
    assign state        = current_state;

    always_comb begin
        next_state     = current_state;
        do_stall       = 1'b0;
        do_branch      = 1'b0;
        do_load_use    = 1'b0;
        wait_increment = 1'b0;
        wait_clear     = 1'b0;
        if (!reset) begin
            unique case (current_state)
                RUN: begin
                    if (mem_pending) begin
                        do_stall   = 1'b1;
                        next_state = MEM_WAIT;
                    end else if (branch_taken) begin
                        do_branch  = 1'b1;
                        next_state = FLUSH;
                    end else if (load_use) begin
                        do_load_use = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmemReady) begin
                        do_stall       = 1'b1;
                        wait_increment = 1'b1;
                    end else begin
                        wait_clear = 1'b1;
                        next_state = RUN;
                        if (branch_taken) begin
                            do_branch  = 1'b1;
                            next_state = FLUSH;
                        end else if (load_use) begin
                            do_load_use = 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // ID/EX holds a bubble here, so load-use cannot fire
                    next_state = RUN;
                    if (mem_pending) begin
                        do_stall   = 1'b1;
                        next_state = MEM_WAIT;
                    end else if (branch_taken) begin
                        do_branch  = 1'b1;
                        next_state = FLUSH;
                    end
                end
                default: next_state = RUN;
            endcase
        end
    end

    always_comb begin
        pcWrite        = 1'b1;
        ifIdWrite      = 1'b1;
        idExWrite      = 1'b1;
        exMemWrite     = 1'b1;
        memWbWrite     = 1'b1;
        ifIdFlush      = 1'b0;
        idExFlush      = 1'b0;
        exMemFlush     = 1'b0;
        memWbFlush     = 1'b0;
        pcSelectBranch = 1'b0;
        if (do_stall) begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            idExWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbWrite = 1'b0;
            memWbFlush = 1'b1;
        end
        if (do_branch) begin
            pcSelectBranch = 1'b1;
            ifIdFlush      = 1'b1;
            idExFlush      = 1'b1;
            exMemFlush     = 1'b1;
        end
        if (do_load_use) begin
            pcWrite   = 1'b0;
            ifIdWrite = 1'b0;
            idExFlush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            current_state <= RUN;
            wait_count    <= '0;
            stallCount    <= '0;
            flushCount    <= '0;
            memError      <= 1'b0;
        end else begin
            current_state <= next_state;
            if (wait_clear) begin
                wait_count <= '0;
            end else if (wait_increment && (wait_count != WAIT_LIMIT)) begin
                wait_count <= wait_count + 1'b1;
            end
            if (wait_increment && (wait_count == WAIT_LAST)) begin
                memError <= 1'b1;
            end
            if (!pcWrite && (stallCount != '1)) begin
                stallCount <= stallCount + 1'b1;
            end
            if (do_branch && (flushCount != '1)) begin
                flushCount <= flushCount + 1'b1;
            end
        end
    end

endmodule
